gpu_cmd_writer: RTL
===================

GPU_CMD_WRITER -- requirements
Module: gpu_cmd_writer

Interface
REQ-001 Parameter CMD_BASE, 16'h2000, first byte of the command list.
REQ-002 Parameter CMD_LIMIT, 16'h2800, exclusive end of the command area.
REQ-003 Parameter KICK_ADDR, 16'h0204, kick byte polled by the graphics executor.
REQ-004 Parameter QUIET, 359200, clocks to hold off after a kick (one 800x449 frame).
REQ-005 clock  in  1  single clock.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_op  in  8  opcode: 01 BLOCK, 02 BDRAW, 03 SPRITE.
REQ-010 cmd_x1, cmd_y1, cmd_x2, cmd_y2  in  16 each  signed coordinates or operands.
REQ-011 cmd_cl  in  8  colour or opacity byte.
REQ-012 flush  in  1  single-cycle pulse: terminate the list and kick the executor.
REQ-013 address  out  16  memory write address.
REQ-014 wdata  out  8  memory write data.
REQ-015 we  out  1  write strobe, one byte per high cycle.
REQ-016 full  out  1  no room for another command.
REQ-017 busy  out  1  state is not IDLE, or a flush is pending.

Function
REQ-018 States: IDLE, WRITE, TERM, KICK, QUIET.
REQ-019 cmd_ready is high only in IDLE, with full low and no pending flush.
REQ-020 On acceptance, all fields are latched and the block enters WRITE.
- WRITE emits 10 bytes on consecutive cycles: op, x1 lo, x1 hi, y1 lo, y1 hi, x2 lo, x2 hi, y2 lo, y2 hi, cl.
- Byte k goes to address ptr+k with we=1.
REQ-021 After the 10th byte, ptr advances by 10 and the block returns to IDLE, or goes to TERM if a flush is pending.
REQ-022 Latency: the first byte's we appears the cycle after acceptance; back-to-back commands are 11 cycles apart minimum.
REQ-023 full = (ptr + 11 > CMD_LIMIT); 11 covers 10 command bytes plus the terminator.
REQ-024 flush is latched into a pending flag in any state, and the pulse is never lost.
- The pending flag is serviced from IDLE, or directly after WRITE completes.
REQ-025 Simultaneous cmd_valid handshake and flush in IDLE: the command is written first, then the flush runs, and the flush includes that command.
REQ-026 Flush with ptr == CMD_BASE (empty list): the pending flag clears, no writes occur, and the block stays in IDLE.
REQ-027 TERM writes 8'hFF at ptr for one cycle with we=1, then goes to KICK.
REQ-028 KICK increments an 8-bit kick counter (wraps FF->00) and writes the new value to KICK_ADDR.
- ptr returns to CMD_BASE.
- The block goes to QUIET.
REQ-029 QUIET counts QUIET cycles with we=0, then returns to IDLE; a flush arriving during QUIET stays pending.
REQ-030 The kick value always differs from the previously written value, so the executor detects every kick.
REQ-031 we is high only in WRITE, TERM and KICK; address and wdata are don't-care when we=0 but are held stable.
REQ-032 A full list is never overwritten; producers must flush to make room.

Reset
REQ-033 reset_n low asynchronously forces:
- state IDLE, ptr CMD_BASE, kick counter 0, pending flag 0, QUIET counter 0;
- we 0, address 0, wdata 0, cmd_ready 0 while low.
REQ-034 Reset mid-WRITE abandons the partial command with no terminator and no kick.
REQ-035 The first kick after reset writes 8'h01.

Structure
REQ-036 Shared package gpu_cmd_pkg holds:
- opcode constants OP_BLOCK=01, OP_BDRAW=02, OP_SPRITE=03, OP_FIN=FF;
- CMD_BYTES=10;
- default CMD_BASE, CMD_LIMIT and KICK_ADDR.
REQ-037 One sub-module is natural: gpu_cmd_serializer, which converts latched fields and a byte index into address and wdata.

Verification
REQ-038 One BLOCK command (x1=10, y1=20, x2=100, y2=50, cl=0C), then flush. Required writes, in order:
- 2000..2009 = 01 0A 00 14 00 64 00 32 00 0C;
- 200A = FF;
- 0204 = 01.
REQ-039 Command with a flush pulse in the acceptance cycle: terminator at 200A, kick 01, cmd_ready low for the QUIET cycles that follow.
REQ-040 Fill the area with 204 commands: full rises after the 204th, since ptr=27F8 and ptr+11 > 2800.
- cmd_ready stays low while cmd_valid is held.
- A flush writes FF at 27F8 and clears full.
REQ-041 Flush on an empty list: no we pulse at all, busy returns low within 2 cycles.
REQ-042 reset_n asserted at the 5th byte of a command: we drops immediately with no FF or 0204 write.
- The next command is written from 2000, and its flush kicks 01.
REQ-043 256 flushes: the kick value wraps FF->00, with every consecutive pair of kick values different.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command-list writer.
// Holds the opcode values, the fixed command size, the default memory map
// (command area and kick byte), the FSM state type and the "list full" test.
package gpu_cmd_pkg;

  localparam logic [7:0] OP_BLOCK  = 8'h01;
  localparam logic [7:0] OP_BDRAW  = 8'h02;
  localparam logic [7:0] OP_SPRITE = 8'h03;
  localparam logic [7:0] OP_FIN    = 8'hFF;

  localparam logic [3:0] CMD_BYTES = 4'd10;

  localparam logic [15:0] DEF_CMD_BASE  = 16'h2000;
  localparam logic [15:0] DEF_CMD_LIMIT = 16'h2800;
  localparam logic [15:0] DEF_KICK_ADDR = 16'h0204;
  localparam int unsigned DEF_QUIET     = 359200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_TERM,
    ST_KICK,
    ST_QUIET
  } state_e;

  // A command may only be accepted if its 10 bytes plus the terminator fit
  // below the limit; computed in 17 bits so the sum cannot wrap.
  function automatic logic list_full(input logic [15:0] ptr, input logic [15:0] limit);
    return ({1'b0, ptr} + {13'd0, CMD_BYTES} + 17'd1) > {1'b0, limit};
  endfunction

endpackage

// File: rtl/gpu_cmd_serializer.sv
// Maps a command's fields and a byte index onto one memory write.
// Ports:
//   ptr_i            start address of the command in the list
//   idx_i            byte index 0..9
//   op_i, cl_i       opcode and colour byte
//   x1_i..y2_i       16-bit operands, emitted low byte first
//   addr_o, data_o   address (ptr_i + idx_i) and byte for that index
module gpu_cmd_serializer
  import gpu_cmd_pkg::*;
(
  input  logic [15:0] ptr_i,
  input  logic [3:0]  idx_i,
  input  logic [7:0]  op_i,
  input  logic [15:0] x1_i,
  input  logic [15:0] y1_i,
  input  logic [15:0] x2_i,
  input  logic [15:0] y2_i,
  input  logic [7:0]  cl_i,
  output logic [15:0] addr_o,
  output logic [7:0]  data_o
);

  assign addr_o = ptr_i + {12'd0, idx_i};

  always_comb begin
    case (idx_i)
      4'd0:    data_o = op_i;
      4'd1:    data_o = x1_i[7:0];
      4'd2:    data_o = x1_i[15:8];
      4'd3:    data_o = y1_i[7:0];
      4'd4:    data_o = y1_i[15:8];
      4'd5:    data_o = x2_i[7:0];
      4'd6:    data_o = x2_i[15:8];
      4'd7:    data_o = y2_i[7:0];
      4'd8:    data_o = y2_i[15:8];
      4'd9:    data_o = cl_i;
      default: data_o = OP_FIN;
    endcase
  end

endmodule

// File: rtl/gpu_cmd_writer.sv
// Builds a command list in memory for a polling graphics executor.
// Accepted commands are serialised as 10 bytes at the list pointer; a flush
// appends the FF terminator, bumps the kick byte at KICK_ADDR, rewinds the
// list and then holds off for QUIET clocks while the executor runs.
// Ports:
//   clock, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op, cmd_x1..cmd_y2,  command fields
//   cmd_cl
//   flush                    single-cycle request to terminate and kick
//   address, wdata, we       byte-wide memory write port (registered)
//   full                     no room for another command
//   busy                     not idle, or a flush is pending
module gpu_cmd_writer
  import gpu_cmd_pkg::*;
#(
  parameter logic [15:0] CMD_BASE  = DEF_CMD_BASE,
  parameter logic [15:0] CMD_LIMIT = DEF_CMD_LIMIT,
  parameter logic [15:0] KICK_ADDR = DEF_KICK_ADDR,
  parameter int unsigned QUIET     = DEF_QUIET
)(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [15:0] cmd_x1,
  input  logic [15:0] cmd_y1,
  input  logic [15:0] cmd_x2,
  input  logic [15:0] cmd_y2,
  input  logic [7:0]  cmd_cl,
  input  logic        flush,
  output logic [15:0] address,
  output logic [7:0]  wdata,
  output logic        we,
  output logic        full,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  kick_q, kick_d;
  logic        pend_q, pend_d;
  logic [31:0] quiet_q, quiet_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  op_q, op_d, cl_q, cl_d;
  logic [15:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;

  logic        accept, consume;
  logic        in_idle;
  logic [3:0]  ser_idx;
  logic [15:0] ser_addr;
  logic [7:0]  ser_data;

  // Outputs are registered, so the byte for the next cycle is computed now:
  // in IDLE that is byte 0 straight from the inputs, in WRITE it is the
  // byte after the one currently on the bus.
  assign in_idle = (state_q == ST_IDLE);
  assign ser_idx = in_idle ? 4'd0 : idx_q + 4'd1;

  gpu_cmd_serializer u_ser (
    .ptr_i  (ptr_q),
    .idx_i  (ser_idx),
    .op_i   (in_idle ? cmd_op : op_q),
    .x1_i   (in_idle ? cmd_x1 : x1_q),
    .y1_i   (in_idle ? cmd_y1 : y1_q),
    .x2_i   (in_idle ? cmd_x2 : x2_q),
    .y2_i   (in_idle ? cmd_y2 : y2_q),
    .cl_i   (in_idle ? cmd_cl : cl_q),
    .addr_o (ser_addr),
    .data_o (ser_data)
  );

  assign accept = cmd_valid && ready_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    kick_d  = kick_q;
    quiet_d = quiet_q;
    idx_d   = idx_q;
    op_d    = op_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    cl_d    = cl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    consume = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          x2_d    = cmd_x2;
          y2_d    = cmd_y2;
          cl_d    = cmd_cl;
          idx_d   = 4'd0;
          state_d = ST_WRITE;
          we_d    = 1'b1;
          addr_d  = ser_addr;
          wdata_d = ser_data;
        end else if (pend_q) begin
          // An empty list is not kicked; the request is simply dropped.
          consume = 1'b1;
          if (ptr_q != CMD_BASE) begin
            state_d = ST_TERM;
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = OP_FIN;
          end
        end
      end
      ST_WRITE: begin
        if (idx_q != CMD_BYTES - 4'd1) begin
          idx_d   = idx_q + 4'd1;
          we_d    = 1'b1;
          addr_d  = ser_addr;
          wdata_d = ser_data;
        end else begin
          ptr_d = ptr_q + {12'd0, CMD_BYTES};
          if (pend_q || flush) begin
            consume = 1'b1;
            state_d = ST_TERM;
            we_d    = 1'b1;
            addr_d  = ptr_d;
            wdata_d = OP_FIN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_TERM: begin
        // +1 guarantees the executor sees a changed byte on every kick.
        kick_d  = kick_q + 8'd1;
        state_d = ST_KICK;
        we_d    = 1'b1;
        addr_d  = KICK_ADDR;
        wdata_d = kick_d;
        ptr_d   = CMD_BASE;
      end
      ST_KICK: begin
        state_d = ST_QUIET;
        quiet_d = 32'd0;
      end
      ST_QUIET: begin
        if (quiet_q == QUIET - 1) begin
          state_d = ST_IDLE;
          quiet_d = 32'd0;
        end else begin
          quiet_d = quiet_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush arriving in the very cycle a terminate begins is covered by
    // that terminate, so it merges instead of queueing a second one.
    pend_d  = (pend_q || flush) && !consume;
    ready_d = (state_d == ST_IDLE) && !list_full(ptr_d, CMD_LIMIT) && !pend_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= CMD_BASE;
      kick_q  <= 8'd0;
      pend_q  <= 1'b0;
      quiet_q <= 32'd0;
      idx_q   <= 4'd0;
      op_q    <= 8'd0;
      x1_q    <= 16'd0;
      y1_q    <= 16'd0;
      x2_q    <= 16'd0;
      y2_q    <= 16'd0;
      cl_q    <= 8'd0;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      kick_q  <= kick_d;
      pend_q  <= pend_d;
      quiet_q <= quiet_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      cl_q    <= cl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign address   = addr_q;
  assign wdata     = wdata_q;
  assign we        = we_q;
  assign full      = list_full(ptr_q, CMD_LIMIT);
  assign busy      = (state_q != ST_IDLE) || pend_q;

endmodule
